gin_tile_streamer: RTL and testbench



---
 rtl/gin_tile_streamer.sv | 167 ++++++++++++++++
 tb/tb_gin_tile_streamer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gin_tile_streamer.sv
// GLB-to-GIN tile streamer: walks rows x cols x len words, reads them from the GLB,
// and feeds the GIN master port from a credit-guarded FIFO carrying {data, tag_X, tag_Y}.
module gin_tile_streamer #(
  parameter int DATA_BITS  = 32,
  parameter int XID_BITS   = 5,
  parameter int YID_BITS   = 4,
  parameter int ADDR_BITS  = 16,
  parameter int LEN_BITS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [YID_BITS-1:0]  rows,
  input  logic [XID_BITS-1:0]  cols,
  input  logic [LEN_BITS-1:0]  len,
  input  logic [YID_BITS-1:0]  y_base,
  input  logic [XID_BITS-1:0]  x_base,
  output logic                 busy,
  output logic                 done,
  output logic                 glb_rd_en,
  output logic [ADDR_BITS-1:0] glb_rd_addr,
  input  logic [DATA_BITS-1:0] glb_rd_data,
  output logic                 GIN_valid,
  input  logic                 GIN_ready,
  output logic [DATA_BITS-1:0] GIN_data,
  output logic [XID_BITS-1:0]  tag_X,
  output logic [YID_BITS-1:0]  tag_Y
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = DATA_BITS + YID_BITS + XID_BITS;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_BITS-1:0] addr_q;
  logic [YID_BITS-1:0]  rows_q, y_base_q, y_cnt, tag_y_p1;
  logic [XID_BITS-1:0]  cols_q, x_base_q, x_cnt, tag_x_p1;
  logic [LEN_BITS-1:0]  len_q, k_cnt;
  logic                 vld_p1;

  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       used;

  logic accept, zero_size, k_last, x_last, y_last, last_rd, credit_ok, push, pop;

  always_comb begin
    accept    = (state == IDLE) && start;
    zero_size = (rows == '0) || (cols == '0) || (len == '0);
    k_last    = (k_cnt == len_q - LEN_BITS'(1));
    x_last    = (x_cnt == cols_q - XID_BITS'(1));
    y_last    = (y_cnt == rows_q - YID_BITS'(1));
    last_rd   = k_last && x_last && y_last;
    // Credit uses registered occupancy only; a pop this cycle frees space next cycle.
    used      = {1'b0, fifo_count} + (CNT_W+1)'(vld_p1);
    credit_ok = used < (CNT_W+1)'(FIFO_DEPTH);
    push      = vld_p1;
    pop       = GIN_valid && GIN_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // An empty tile still spends one busy cycle in DRAIN so done lands at t+2.
      IDLE:    if (start) state_nxt = zero_size ? DRAIN : RUN;
      RUN:     if (glb_rd_en && last_rd) state_nxt = DRAIN;
      DRAIN:   if ((fifo_count == '0) && !vld_p1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    glb_rd_en = (state == RUN) && credit_ok;
  end

  // Stage p0: tile walk counters and address generation
  always_ff @(posedge clk) begin
    if (!rst) begin
      k_cnt <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      k_cnt <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (glb_rd_en) begin
      if (!k_last) begin
        k_cnt <= k_cnt + LEN_BITS'(1);
      end else begin
        k_cnt <= '0;
        if (!x_last) begin
          x_cnt <= x_cnt + XID_BITS'(1);
        end else begin
          x_cnt <= '0;
          y_cnt <= y_cnt + YID_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= base_addr;
      rows_q   <= rows;
      cols_q   <= cols;
      len_q    <= len;
      y_base_q <= y_base;
      x_base_q <= x_base;
    end else if (glb_rd_en) begin
      addr_q <= addr_q + ADDR_BITS'(1);
    end
  end

  assign glb_rd_addr = addr_q;

  // Stage p1: tags ride alongside the GLB read latency
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= glb_rd_en;
  end

  always_ff @(posedge clk) begin
    tag_y_p1 <= y_base_q + y_cnt;
    tag_x_p1 <= x_base_q + x_cnt;
  end

  // Stage p2: FIFO push of returning read data, pop toward GIN
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {glb_rd_data, tag_y_p1, tag_x_p1};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign GIN_valid = (fifo_count != '0);

  always_comb begin
    {GIN_data, tag_Y, tag_X} = GIN_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_gin_tile_streamer.sv
// Directed bench for gin_tile_streamer: GLB read model, transfer log, and
// immediate-assertion checks against hand-derived expectations.
module tb_gin_tile_streamer;
  localparam int DW = 32;
  localparam int XW = 5;
  localparam int YW = 4;
  localparam int AW = 16;
  localparam int LW = 8;
  localparam int FD = 4;
  localparam int EW = DW + YW + XW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [YW-1:0] rows = '0;
  logic [XW-1:0] cols = '0;
  logic [LW-1:0] len = '0;
  logic [YW-1:0] y_base = '0;
  logic [XW-1:0] x_base = '0;
  logic          busy, done, glb_rd_en, GIN_valid;
  logic [AW-1:0] glb_rd_addr;
  logic [DW-1:0] glb_rd_data = '0;
  logic          GIN_ready = 1'b0;
  logic [DW-1:0] GIN_data;
  logic [XW-1:0] tag_X;
  logic [YW-1:0] tag_Y;

  gin_tile_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .rows(rows),
    .cols(cols), .len(len), .y_base(y_base), .x_base(x_base), .busy(busy),
    .done(done), .glb_rd_en(glb_rd_en), .glb_rd_addr(glb_rd_addr),
    .glb_rd_data(glb_rd_data), .GIN_valid(GIN_valid), .GIN_ready(GIN_ready),
    .GIN_data(GIN_data), .tag_X(tag_X), .tag_Y(tag_Y)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc_no = 0;
  int n_done = 0, done_cyc = -1, n_rd = 0, n_valid = 0;
  int out_cnt = 0, max_out = 0, stall_viol = 0;
  logic [AW-1:0] rd_q[$];
  logic [EW-1:0] xf_q[$];
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_head = '0;
  logic [DW-1:0] nxt_data = '0;

  function automatic logic [DW-1:0] gdata(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  function automatic logic [EW-1:0] ent(input logic [AW-1:0] a, input logic [YW-1:0] y,
                                        input logic [XW-1:0] x);
    return {gdata(a), y, x};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sample one cycle at the falling edge, then advance past the rising edge.
  task automatic cyc();
    logic [EW-1:0] head;
    @(negedge clk);
    head = {GIN_data, tag_Y, tag_X};
    if (prev_stall && (!GIN_valid || head !== prev_head)) stall_viol++;
    prev_stall = GIN_valid && !GIN_ready;
    prev_head  = head;
    nxt_data   = glb_rd_en ? gdata(glb_rd_addr) : 32'hDEAD_BEEF;
    if (glb_rd_en) begin
      rd_q.push_back(glb_rd_addr);
      n_rd++;
      out_cnt++;
      if (out_cnt > max_out) max_out = out_cnt;
    end
    if (GIN_valid) n_valid++;
    if (GIN_valid && GIN_ready) begin
      xf_q.push_back(head);
      out_cnt--;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc_no;
    end
    @(posedge clk);
    #1;
    glb_rd_data = nxt_data;
    cyc_no++;
  endtask

  task automatic clear();
    rd_q.delete();
    xf_q.delete();
    n_rd = 0; n_valid = 0; n_done = 0; done_cyc = -1;
    out_cnt = 0; max_out = 0; stall_viol = 0;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [YW-1:0] r, input logic [XW-1:0] c,
                        input logic [LW-1:0] l, input logic [YW-1:0] yb, input logic [XW-1:0] xb,
                        output int t);
    base_addr = b; rows = r; cols = c; len = l; y_base = yb; x_base = xb;
    start = 1'b1;
    t = cyc_no;
    cyc();
    start = 1'b0;
    base_addr = 16'hBAD0; rows = 4'd9; cols = 5'd17; len = 8'd77; y_base = 4'd6; x_base = 5'd11;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int g = 0;
    while (n_done == 0 && g < bound) begin
      cyc();
      g++;
    end
    chk(tag, 64'(n_done != 0), 64'd1);
  endtask

  task automatic check_stream(input string tag, input int b, input int yb, input int xb,
                              input int r, input int c, input int l);
    int idx = 0;
    chk({tag, "_count"}, 64'(xf_q.size()), 64'(r * c * l));
    for (int y = 0; y < r; y++)
      for (int x = 0; x < c; x++)
        for (int k = 0; k < l; k++) begin
          if (idx < xf_q.size())
            chk({tag, "_word"}, 64'(xf_q[idx]), 64'(ent(AW'(b + idx), YW'(yb + y), XW'(xb + x))));
          idx++;
        end
  endtask

  task automatic pad_logs();
    while (xf_q.size() < 8) xf_q.push_back('0);
    while (rd_q.size() < 8) rd_q.push_back('0);
  endtask

  initial begin
    int t, g;

    // Reset state
    cyc(); cyc();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(glb_rd_en), 64'd0);
    chk("rst_valid", 64'(GIN_valid), 64'd0);
    chk("rst_head", 64'({GIN_data, tag_Y, tag_X}), 64'd0);
    rst = 1'b1;
    cyc();

    // Basic stream
    clear();
    GIN_ready = 1'b1;
    chk("basic_idle_busy", 64'(busy), 64'd0);
    launch(16'h0010, 4'd1, 5'd2, 8'd3, 4'd2, 5'd4, t);
    chk("basic_t1_busy", 64'(busy), 64'd1);
    chk("basic_t1_rd_en", 64'(glb_rd_en), 64'd1);
    chk("basic_t1_addr", 64'(glb_rd_addr), 64'h10);
    chk("basic_t1_valid", 64'(GIN_valid), 64'd0);
    cyc();
    chk("basic_t2_valid", 64'(GIN_valid), 64'd0);
    chk("basic_t2_addr", 64'(glb_rd_addr), 64'h11);
    cyc();
    chk("basic_t3_valid", 64'(GIN_valid), 64'd1);
    chk("basic_t3_head", 64'({GIN_data, tag_Y, tag_X}), 64'(ent(16'h0010, 4'd2, 5'd4)));
    wait_done("basic_done_seen", 50);
    chk("basic_done_lat", 64'(done_cyc - t), 64'd10);
    chk("basic_busy_after", 64'(busy), 64'd0);
    cyc(); cyc();
    chk("basic_done_once", 64'(n_done), 64'd1);
    chk("basic_nreads", 64'(n_rd), 64'd6);
    pad_logs();
    chk("basic_rd_first", 64'(rd_q[0]), 64'h10);
    chk("basic_rd_last", 64'(rd_q[5]), 64'h15);
    xf_q = xf_q[0:5];
    check_stream("basic", 16'h10, 2, 4, 1, 2, 3);

    // Backpressure: GIN_ready low for 10 cycles from the first valid
    clear();
    GIN_ready = 1'b0;
    launch(16'h0010, 4'd1, 5'd2, 8'd3, 4'd2, 5'd4, t);
    while (cyc_no < t + 3) cyc();
    chk("bp_first_valid", 64'(GIN_valid), 64'd1);
    chk("bp_head_t3", 64'({GIN_data, tag_Y, tag_X}), 64'(ent(16'h0010, 4'd2, 5'd4)));
    while (cyc_no < t + 12) cyc();
    chk("bp_head_t12", 64'({GIN_data, tag_Y, tag_X}), 64'(ent(16'h0010, 4'd2, 5'd4)));
    chk("bp_rd_stalled", 64'(glb_rd_en), 64'd0);
    chk("bp_outstanding", 64'(max_out), 64'(FD));
    cyc();
    GIN_ready = 1'b1;
    wait_done("bp_done_seen", 60);
    cyc();
    chk("bp_max_outstanding", 64'(max_out), 64'(FD));
    chk("bp_head_stable", 64'(stall_viol), 64'd0);
    chk("bp_done_once", 64'(n_done), 64'd1);
    check_stream("bp", 16'h10, 2, 4, 1, 2, 3);

    // Tag and address wrap
    clear();
    launch(16'hFFFF, 4'd2, 5'd2, 8'd1, 4'd15, 5'd31, t);
    wait_done("wrap_done_seen", 50);
    cyc();
    chk("wrap_count", 64'(xf_q.size()), 64'd4);
    chk("wrap_nreads", 64'(n_rd), 64'd4);
    pad_logs();
    chk("wrap_w0", 64'(xf_q[0]), 64'(ent(16'hFFFF, 4'd15, 5'd31)));
    chk("wrap_w1", 64'(xf_q[1]), 64'(ent(16'h0000, 4'd15, 5'd0)));
    chk("wrap_w2", 64'(xf_q[2]), 64'(ent(16'h0001, 4'd0, 5'd31)));
    chk("wrap_w3", 64'(xf_q[3]), 64'(ent(16'h0002, 4'd0, 5'd0)));
    chk("wrap_rd0", 64'(rd_q[0]), 64'hFFFF);
    chk("wrap_rd1", 64'(rd_q[1]), 64'h0000);

    // Zero-size tile
    clear();
    launch(16'h0030, 4'd1, 5'd1, 8'd0, 4'd0, 5'd0, t);
    chk("zero_t1_busy", 64'(busy), 64'd1);
    chk("zero_t1_done", 64'(done), 64'd0);
    cyc();
    chk("zero_t2_done", 64'(done), 64'd1);
    chk("zero_t2_busy", 64'(busy), 64'd0);
    cyc();
    chk("zero_t3_done", 64'(done), 64'd0);
    cyc();
    chk("zero_nreads", 64'(n_rd), 64'd0);
    chk("zero_nvalid", 64'(n_valid), 64'd0);
    chk("zero_done_once", 64'(n_done), 64'd1);

    // Ignored start while busy, then mid-tile reset
    clear();
    launch(16'h0040, 4'd1, 5'd2, 8'd3, 4'd2, 5'd4, t);
    cyc();
    base_addr = 16'h0080; len = 8'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_rd_en", 64'(glb_rd_en), 64'd0);
    chk("mrst_valid", 64'(GIN_valid), 64'd0);
    chk("mrst_head", 64'({GIN_data, tag_Y, tag_X}), 64'd0);
    cyc();
    chk("mrst_valid_t7", 64'(GIN_valid), 64'd0);
    chk("mrst_prefix_count", 64'(xf_q.size()), 64'd3);
    pad_logs();
    chk("mrst_w0", 64'(xf_q[0]), 64'(ent(16'h0040, 4'd2, 5'd4)));
    chk("mrst_w1", 64'(xf_q[1]), 64'(ent(16'h0041, 4'd2, 5'd4)));
    chk("mrst_w2", 64'(xf_q[2]), 64'(ent(16'h0042, 4'd2, 5'd4)));
    chk("mrst_rd2", 64'(rd_q[2]), 64'h42);
    chk("mrst_no_done", 64'(n_done), 64'd0);
    cyc();
    clear();
    launch(16'h0010, 4'd1, 5'd2, 8'd3, 4'd2, 5'd4, t);
    wait_done("after_rst_done_seen", 50);
    cyc();
    chk("after_rst_done_once", 64'(n_done), 64'd1);
    check_stream("after_rst", 16'h10, 2, 4, 1, 2, 3);

    // Random GIN_ready over a 4x4x8 tile
    clear();
    GIN_ready = 1'($urandom_range(0, 1));
    launch(16'h0200, 4'd4, 5'd4, 8'd8, 4'd1, 5'd3, t);
    g = 0;
    while (n_done == 0 && g < 3000) begin
      GIN_ready = 1'($urandom_range(0, 1));
      cyc();
      g++;
    end
    GIN_ready = 1'b1;
    chk("rand_done_seen", 64'(n_done != 0), 64'd1);
    cyc(); cyc(); cyc();
    chk("rand_done_once", 64'(n_done), 64'd1);
    chk("rand_head_stable", 64'(stall_viol), 64'd0);
    chk("rand_max_outstanding", 64'(max_out <= FD), 64'd1);
    check_stream("rand", 16'h200, 1, 3, 4, 4, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
